// File: rtl/cdc_xfer_arbiter_if.sv
// Requester / crossing-bus bundle for cdc_xfer_arbiter.
// The slave modport is the arbiter's view; master is the requester/far-side view.
interface cdc_xfer_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int W     = 8
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [W-1:0]       xfer_data;
    logic               xfer_tog;
    logic               ack_tog_sync;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               done;
    logic               timeout_err;

    modport slave (
        input  req_valid, req_data, ack_tog_sync,
        output req_ready, xfer_data, xfer_tog, grant_id, busy, done, timeout_err
    );

    modport master (
        output req_valid, req_data, ack_tog_sync,
        input  req_ready, xfer_data, xfer_tog, grant_id, busy, done, timeout_err
    );
endinterface

// File: rtl/cdc_xfer_arbiter.sv
// Source side of a toggle-handshake CDC: round-robin requester arbiter feeding one crossing bus.
// Optional WAIT_ACK abort enabled by defining CDC_XFER_TIMEOUT_EN.
module cdc_xfer_arbiter #(
    parameter int N_REQ          = 2,
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    cdc_xfer_arbiter_if.slave      io
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK} state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] win;
    logic          found;
    logic          eligible;
    logic [W-1:0]  xfer_data_q;
    logic          xfer_tog_q;
    logic [GW-1:0] grant_id_q;
    logic          busy_q;
    logic          done_q;
    logic          timeout_err_q;

    // Rotating priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            automatic int idx = (int'(ptr) + k) % N_REQ;
            if (!found && io.req_valid[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // A toggle still in flight (ack != tog) blocks every grant.
    assign eligible     = (state == IDLE) && (io.ack_tog_sync == xfer_tog_q);
    assign io.req_ready = (eligible && found) ? (N_REQ'(1) << win) : '0;

`ifdef CDC_XFER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            xfer_data_q   <= '0;
            xfer_tog_q    <= 1'b0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef CDC_XFER_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (eligible && found) begin
                        xfer_data_q <= io.req_data[int'(win)*W +: W];
                        grant_id_q  <= win;
                        ptr         <= GW'((int'(win) + 1) % N_REQ);
                        busy_q      <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Data has been stable a full cycle before the toggle moves.
                    xfer_tog_q <= ~xfer_tog_q;
                    state      <= WAIT_ACK;
`ifdef CDC_XFER_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (io.ack_tog_sync == xfer_tog_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
`ifdef CDC_XFER_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Adopt the far side's toggle so the next grant is not blocked.
                        xfer_tog_q    <= io.ack_tog_sync;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.xfer_data   = xfer_data_q;
    assign io.xfer_tog    = xfer_tog_q;
    assign io.grant_id    = grant_id_q;
    assign io.busy        = busy_q;
    assign io.done        = done_q;
`ifdef CDC_XFER_TIMEOUT_EN
    assign io.timeout_err = timeout_err_q;
`else
    assign io.timeout_err = 1'b0;
`endif
endmodule
